// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-client SRAM port arbiter: phase encoding,
// default bus widths and the client-index type.
package sram_arb_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 8;
    localparam int CID_W  = 1;

    typedef logic [CID_W-1:0] cid_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        STROBE = 2'b10,
        HOLD   = 2'b11
    } state_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Client handshakes plus the SRAM pin bundle. The master modport is the arbiter's
// view; the slave modport is the surrounding clients and the SRAM chip.
interface sram_port_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;

    logic [DW-1:0] rdata;

    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          sram_cs;
    logic          sram_oe;
    logic          sram_we;

    logic          busy;
    cid_t          grant_id;

    modport master (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  sram_rdata,
        output ack0, ack1, rdata,
        output sram_addr, sram_wdata, sram_cs, sram_oe, sram_we,
        output busy, grant_id
    );

    modport slave (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output sram_rdata,
        input  ack0, ack1, rdata,
        input  sram_addr, sram_wdata, sram_cs, sram_oe, sram_we,
        input  busy, grant_id
    );

endinterface

// File: rtl/sram_arb_grant.sv
// Combinational winner selection: the pointer client wins if it is requesting,
// otherwise the other client. A constant pointer of 0 gives fixed priority.
module sram_arb_grant
    import sram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  cid_t ptr,
    output cid_t winner,
    output logic valid
);

    logic ptr_req;

    always_comb begin
        // NOTE: every output gets a value before any branch, so no path leaves
        // a variable unassigned and no latch is inferred.
        valid   = req0 | req1;
        winner  = ptr;
        ptr_req = (ptr == 1'b1) ? req1 : req0;
        if (!ptr_req) begin
            winner = ~ptr;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-client arbiter for a 32x8 async SRAM; every access runs SETUP/STROBE/HOLD.
// Define SRAM_ARB_ROUND_ROBIN_EN for alternating priority; default is fixed priority to client 0.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input logic                 clk,
    input logic                 reset,
    sram_port_arbiter_if.master bus
);

    state_t        state;
    logic          cmd_we;
    cid_t          ptr;
    cid_t          winner;
    logic          win_valid;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Pointer moves to the client that was not just served, on its ack cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (state == HOLD) begin
            ptr <= ~bus.grant_id;
        end
    end
`else
    assign ptr = '0;
`endif

    sram_arb_grant u_grant (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .ptr    (ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    always_comb begin
        win_we    = bus.we0;
        win_addr  = bus.addr0;
        win_wdata = bus.wdata0;
        if (winner == 1'b1) begin
            win_we    = bus.we1;
            win_addr  = bus.addr1;
            win_wdata = bus.wdata1;
        end
    end

    // sram_addr/sram_wdata double as the latched command; only the direction
    // needs its own register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cmd_we         <= 1'b0;
            bus.ack0       <= 1'b0;
            bus.ack1       <= 1'b0;
            bus.rdata      <= '0;
            bus.sram_addr  <= '0;
            bus.sram_wdata <= '0;
            bus.sram_cs    <= 1'b0;
            bus.sram_oe    <= 1'b0;
            bus.sram_we    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.grant_id   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register here
            // updates from the values present before this clock edge.
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    bus.sram_cs <= 1'b0;
                    bus.sram_oe <= 1'b0;
                    bus.sram_we <= 1'b0;
                    if (win_valid) begin
                        state         <= SETUP;
                        bus.busy      <= 1'b1;
                        bus.grant_id  <= winner;
                        cmd_we        <= win_we;
                        bus.sram_addr <= win_addr;
                        if (win_we) begin
                            bus.sram_wdata <= win_wdata;
                        end
                        bus.sram_cs   <= 1'b1;
                        bus.sram_oe   <= ~win_we;
                    end
                end
                SETUP: begin
                    state       <= STROBE;
                    bus.sram_oe <= ~cmd_we;
                    bus.sram_we <= cmd_we;
                end
                STROBE: begin
                    state       <= HOLD;
                    bus.sram_oe <= 1'b0;
                    bus.sram_we <= 1'b0;
                    if (!cmd_we) begin
                        bus.rdata <= bus.sram_rdata;
                    end
                    bus.ack0    <= (bus.grant_id == 1'b0);
                    bus.ack1    <= (bus.grant_id == 1'b1);
                end
                HOLD: begin
                    state       <= IDLE;
                    bus.busy    <= 1'b0;
                    bus.sram_cs <= 1'b0;
                    bus.sram_oe <= 1'b0;
                    bus.sram_we <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    bus.busy    <= 1'b0;
                    bus.sram_cs <= 1'b0;
                    bus.sram_oe <= 1'b0;
                    bus.sram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
